// File: rtl/alib_ram_pkg.sv
// alib_ram_pkg: definitions shared by the RAM arbiter and the RAM primitives.
//   state_t          - arbiter sequencer states (WAKE -> CLEAR -> RUN)
//   alib_addr_width  - address width for a given depth. It must match the
//                      address width used by alib_bram/alib_uram.
package alib_ram_pkg;

  typedef enum logic [1:0] {
    ST_WAKE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // $clog2(depth-1) mirrors the RAM primitives. Depth 2 is floored to one bit.
  function automatic int unsigned alib_addr_width(input int unsigned depth);
    return (depth > 2) ? $clog2(depth - 1) : 1;
  endfunction

endpackage

// File: rtl/alib_rr_arbiter.sv
// alib_rr_arbiter: purely combinational round-robin arbiter.
//   req     in  NUM_REQ : request vector
//   ptr     in  IW      : index of the previous winner. The search starts at ptr+1.
//   en      in  1       : when low, nothing is granted
//   gnt     out NUM_REQ : one-hot grant
//   gnt_idx out IW      : binary index of the winner. It is 0 when there is no grant.
module alib_rr_arbiter #(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      gnt_idx
);

  int unsigned idx;
  logic        found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    // Visit ptr+1 .. ptr+NUM_REQ (mod NUM_REQ). The last position visited is ptr itself.
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = (32'(ptr) + off) % NUM_REQ;
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/alib_ram_arbiter.sv
// alib_ram_arbiter: shares one single-port RAM among NUM_REQ requesters.
// After reset it enables the RAM and, optionally, zero-fills every word.
// It then grants at most one read or write per cycle in round-robin order.
// Read data returns one cycle after the grant on a shared bus.
//   clk, rst (async, active-low)
//   req_valid/req_ready/req_we : per-requester handshake. Ready is a one-hot grant.
//   req_addr/req_wdata         : flattened per-requester address and write data
//   rsp_valid/rsp_rdata        : one-cycle read response pulse and its data
//   init_done                  : high in RUN
//   ram_en/ram_we/ram_addr/ram_din/ram_dout : RAM primitive pins
module alib_ram_arbiter
  import alib_ram_pkg::*;
#(
  parameter  int unsigned NUM_REQ        = 2,
  parameter  int unsigned DATA_WIDTH     = 8,
  parameter  int unsigned DEPTH          = 1024,
  parameter  bit          CLEAR_ON_RESET = 1'b1,
  localparam int unsigned AW             = alib_addr_width(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*AW-1:0]         req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          init_done,
  output logic                          ram_en,
  output logic                          ram_we,
  output logic [AW-1:0]                 ram_addr,
  output logic [DATA_WIDTH-1:0]         ram_din,
  input  logic [DATA_WIDTH-1:0]         ram_dout
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  state_t                  state, state_nxt;
  logic [AW-1:0]           clr_cnt;
  logic [AW-1:0]           last_addr;
  logic [IW-1:0]           ptr;
  logic [IW-1:0]           rd_id;
  logic                    rd_pend;
  logic                    ram_en_q;
  logic                    arb_en;
  logic [NUM_REQ-1:0]      gnt;
  logic [IW-1:0]           gnt_idx;
  logic                    win_we;
  logic [AW-1:0]           win_addr;
  logic [DATA_WIDTH-1:0]   win_wdata;

  assign arb_en = (state == ST_RUN);

  alib_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_WAKE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_WAKE:  state_nxt = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      ST_CLEAR: if (clr_cnt == AW'(DEPTH - 1)) state_nxt = ST_RUN;
      ST_RUN:   state_nxt = ST_RUN;
      default:  state_nxt = ST_WAKE;
    endcase
  end

  // The clear counter advances only in CLEAR and returns to 0 on leaving CLEAR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      clr_cnt <= '0;
    else if (state == ST_CLEAR && clr_cnt != AW'(DEPTH - 1))
      clr_cnt <= clr_cnt + AW'(1);
    else
      clr_cnt <= '0;
  end

  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        win_we    = req_we[i];
        win_addr  = req_addr[i*AW +: AW];
        win_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    req_ready = gnt;
    ram_we    = 1'b0;
    ram_addr  = last_addr;
    ram_din   = '0;
    unique case (state)
      ST_CLEAR: begin
        ram_we   = 1'b1;
        ram_addr = clr_cnt;
      end
      ST_RUN: begin
        if (|gnt) begin
          ram_we   = win_we;
          ram_addr = win_addr;
          ram_din  = win_wdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_en_q  <= 1'b0;
      ptr       <= IW'(NUM_REQ - 1);
      last_addr <= '0;
      rd_pend   <= 1'b0;
      rd_id     <= '0;
    end else begin
      ram_en_q <= 1'b1;
      rd_pend  <= (|gnt) && !win_we;
      if (|gnt) begin
        ptr       <= gnt_idx;
        last_addr <= win_addr;
        if (!win_we) rd_id <= gnt_idx;
      end
    end
  end

  // The RAM registers its output, so data for the read granted last cycle is on
  // ram_dout now and is passed through without another register.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    if (rd_pend) begin
      rsp_rdata = ram_dout;
      for (int unsigned i = 0; i < NUM_REQ; i++)
        rsp_valid[i] = (rd_id == IW'(i));
    end
  end

  assign init_done = (state == ST_RUN);
  assign ram_en    = ram_en_q;

endmodule

// File: tb/tb_alib_ram_arbiter.sv
// tb_alib_ram_arbiter: bench for alib_ram_arbiter.
//   Instance A: NUM_REQ=3, DEPTH=16, CLEAR_ON_RESET=1. A scoreboard checks read responses.
//   Instance B: NUM_REQ=2, DEPTH=16, CLEAR_ON_RESET=0.
// Each instance has a behavioural RAM with a registered read, preloaded with 0xFF.
module tb_alib_ram_arbiter;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals.
  logic [2:0]  a_valid = '0, a_we = '0, a_ready, a_rsp_valid;
  logic [11:0] a_addr = '0;
  logic [23:0] a_wdata = '0;
  logic [7:0]  a_rsp_rdata, a_ram_din, a_ram_dout;
  logic        a_init_done, a_ram_en, a_ram_we;
  logic [3:0]  a_ram_addr;

  // Instance B signals.
  logic [1:0]  b_valid = '0, b_we = '0, b_ready, b_rsp_valid;
  logic [7:0]  b_addr = '0;
  logic [15:0] b_wdata = '0;
  logic [7:0]  b_rsp_rdata, b_ram_din, b_ram_dout;
  logic        b_init_done, b_ram_en, b_ram_we;
  logic [3:0]  b_ram_addr;

  alib_ram_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8), .DEPTH(16), .CLEAR_ON_RESET(1'b1)) dut_a (
    .clk(clk), .rst(rst_a), .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
    .req_addr(a_addr), .req_wdata(a_wdata), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
    .init_done(a_init_done), .ram_en(a_ram_en), .ram_we(a_ram_we), .ram_addr(a_ram_addr),
    .ram_din(a_ram_din), .ram_dout(a_ram_dout)
  );

  alib_ram_arbiter #(.NUM_REQ(2), .DATA_WIDTH(8), .DEPTH(16), .CLEAR_ON_RESET(1'b0)) dut_b (
    .clk(clk), .rst(rst_b), .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
    .req_addr(b_addr), .req_wdata(b_wdata), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .init_done(b_init_done), .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr),
    .ram_din(b_ram_din), .ram_dout(b_ram_dout)
  );

  // Behavioural single-port RAMs with a registered read.
  logic [7:0] mem_a [16] = '{default: 8'hFF};
  logic [7:0] mem_b [16] = '{default: 8'hFF};
  logic [7:0] a_dout_q = '0, b_dout_q = '0;
  assign a_ram_dout = a_dout_q;
  assign b_ram_dout = b_dout_q;

  always @(posedge clk) begin
    if (a_ram_en) begin
      if (a_ram_we) mem_a[a_ram_addr] <= a_ram_din;
      else          a_dout_q <= mem_a[a_ram_addr];
    end
    if (b_ram_en) begin
      if (b_ram_we) mem_b[b_ram_addr] <= b_ram_din;
      else          b_dout_q <= mem_b[b_ram_addr];
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard for instance A. Each read grant pushes the expected data from
  // the reference memory. The response must arrive exactly one cycle later.
  typedef struct {
    int unsigned id;
    logic [7:0]  data;
    int unsigned cyc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e;
  logic [7:0]  ref_a [16];
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (a_rsp_valid != '0) begin
      if (sbq.size() == 0) begin
        check("rsp_unexpected", 32'(a_rsp_valid), 32'd0);
      end else begin
        e = sbq.pop_front();
        check("rsp_id", 32'(a_rsp_valid), 32'(1) << e.id);
        check("rsp_data", 32'(a_rsp_rdata), 32'(e.data));
        check("rsp_latency", cyc, e.cyc + 1);
      end
    end else begin
      check("rsp_rdata_idle", 32'(a_rsp_rdata), 32'd0);
      if (sbq.size() != 0 && cyc > sbq[0].cyc + 1) begin
        e = sbq.pop_front();
        check("rsp_missing", 32'(a_rsp_valid), 32'(1) << e.id);
      end
    end
    if (rst_a) begin
      for (int i = 0; i < 3; i++) begin
        if (a_valid[i] && a_ready[i]) begin
          if (a_we[i]) ref_a[a_addr[i*4 +: 4]] = a_wdata[i*8 +: 8];
          else sbq.push_back('{id: i, data: ref_a[a_addr[i*4 +: 4]], cyc: cyc});
        end
      end
    end
  end

  // Counts edges from reset release until init_done is seen. Returns at posedge+1.
  task automatic wait_init(input string name, input bit sel_b, input int exp_edges);
    int k;
    k = 0;
    while (k < 40) begin
      @(posedge clk);
      k++;
      #1;
      if (k == 1) check({name, "_ram_en"}, 32'(sel_b ? b_ram_en : a_ram_en), 32'd1);
      if (sel_b ? b_init_done : a_init_done) break;
    end
    check(name, k, exp_edges);
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_ready"},     32'(a_ready),     32'd0);
    check({tag, "_rsp_valid"}, 32'(a_rsp_valid), 32'd0);
    check({tag, "_rsp_rdata"}, 32'(a_rsp_rdata), 32'd0);
    check({tag, "_init_done"}, 32'(a_init_done), 32'd0);
    check({tag, "_ram_en"},    32'(a_ram_en),    32'd0);
    check({tag, "_ram_we"},    32'(a_ram_we),    32'd0);
    check({tag, "_ram_addr"},  32'(a_ram_addr),  32'd0);
    check({tag, "_ram_din"},   32'(a_ram_din),   32'd0);
  endtask

  typedef struct {
    logic [2:0] valid;
    logic [2:0] we;
    logic [2:0] exp_ready;
  } vec_t;

  vec_t tbl[17];

  initial begin
    int idx;
    logic [3:0] exp_addr, last_exp;

    // In row r, requester i uses address (r+i)%16 and write data r*16+i+1.
    tbl[0]  = '{3'b111, 3'b000, 3'b001};
    tbl[1]  = '{3'b111, 3'b000, 3'b010};
    tbl[2]  = '{3'b111, 3'b000, 3'b100};
    tbl[3]  = '{3'b111, 3'b000, 3'b001};
    tbl[4]  = '{3'b111, 3'b000, 3'b010};
    tbl[5]  = '{3'b111, 3'b000, 3'b100};
    tbl[6]  = '{3'b000, 3'b000, 3'b000};
    tbl[7]  = '{3'b011, 3'b011, 3'b001};
    tbl[8]  = '{3'b101, 3'b000, 3'b100};
    tbl[9]  = '{3'b010, 3'b010, 3'b010};
    tbl[10] = '{3'b010, 3'b000, 3'b010};
    tbl[11] = '{3'b001, 3'b000, 3'b001};
    tbl[12] = '{3'b110, 3'b000, 3'b010};
    tbl[13] = '{3'b101, 3'b000, 3'b100};
    tbl[14] = '{3'b011, 3'b000, 3'b001};
    tbl[15] = '{3'b111, 3'b111, 3'b010};
    tbl[16] = '{3'b001, 3'b000, 3'b001};

    #2;
    check_reset_a("rst_a");
    check("rst_b_init_done", 32'(b_init_done), 32'd0);
    check("rst_b_ram_en", 32'(b_ram_en), 32'd0);

    @(posedge clk); #1;
    rst_a = 1'b1;
    wait_init("init_edges_a", 1'b0, 17);
    for (int i = 0; i < 16; i++) ref_a[i] = 8'h00;

    // Table: grant order and muxed RAM controls. The pointer starts at NUM_REQ-1.
    last_exp = '0;
    for (int r = 0; r < 17; r++) begin
      a_valid = tbl[r].valid;
      a_we    = tbl[r].we;
      for (int i = 0; i < 3; i++) begin
        a_addr[i*4 +: 4]  = 4'((r + i) % 16);
        a_wdata[i*8 +: 8] = 8'(r * 16 + i + 1);
      end
      idx = -1;
      for (int i = 0; i < 3; i++) if (tbl[r].exp_ready[i]) idx = i;
      exp_addr = (idx >= 0) ? 4'((r + idx) % 16) : last_exp;
      last_exp = exp_addr;
      @(negedge clk);
      check("tbl_ready", 32'(a_ready), 32'(tbl[r].exp_ready));
      check("tbl_ram_we", 32'(a_ram_we), 32'(|(tbl[r].exp_ready & tbl[r].we)));
      check("tbl_ram_addr", 32'(a_ram_addr), 32'(exp_addr));
      @(posedge clk); #1;
    end
    a_valid = '0;
    a_we    = '0;

    // Requester 1 alone: 16 back-to-back reads of addresses 0..15.
    a_valid = 3'b010;
    for (int k = 0; k < 16; k++) begin
      a_addr[7:4] = 4'(k);
      @(negedge clk);
      check("stream_ready", 32'(a_ready), 32'b010);
      @(posedge clk); #1;
    end
    a_valid = '0;

    // Write 0xA5 to address 5, then read address 5 in the next cycle.
    a_valid = 3'b001; a_we = 3'b001; a_addr[3:0] = 4'd5; a_wdata[7:0] = 8'hA5;
    @(negedge clk);
    check("wr_ready", 32'(a_ready), 32'b001);
    check("wr_ram_din", 32'(a_ram_din), 32'hA5);
    @(posedge clk); #1;
    a_we = '0;
    @(negedge clk);
    check("rd_ready", 32'(a_ready), 32'b001);
    @(posedge clk); #1;
    a_valid = '0;
    @(negedge clk);
    check("raw_rsp_valid", 32'(a_rsp_valid), 32'b001);
    check("raw_rsp_rdata", 32'(a_rsp_rdata), 32'hA5);
    @(posedge clk); #1;

    // Assert reset right after a read grant. The response must never appear.
    a_valid = 3'b100; a_we = '0; a_addr[11:8] = 4'd3;
    @(negedge clk);
    check("midrst_ready", 32'(a_ready), 32'b100);
    @(posedge clk); #1;
    rst_a = 1'b0;
    a_valid = '0;
    sbq.delete();
    #1;
    check_reset_a("midrst");
    @(posedge clk); #1;
    rst_a = 1'b1;
    wait_init("init_edges_rerun", 1'b0, 17);
    for (int i = 0; i < 16; i++) ref_a[i] = 8'h00;
    a_valid = 3'b001; a_we = '0; a_addr[3:0] = 4'd5;
    @(negedge clk);
    check("reclear_ready", 32'(a_ready), 32'b001);
    @(posedge clk); #1;
    a_valid = '0;
    @(negedge clk);
    check("reclear_rsp_valid", 32'(a_rsp_valid), 32'b001);
    check("reclear_rsp_rdata", 32'(a_rsp_rdata), 32'h00);
    @(posedge clk); #1;

    // Instance B has no clear phase.
    rst_b = 1'b1;
    wait_init("init_edges_b", 1'b1, 1);
    b_valid = 2'b01; b_we = 2'b01; b_addr[3:0] = 4'd9; b_wdata[7:0] = 8'h3C;
    @(negedge clk);
    check("b_wr_ready", 32'(b_ready), 32'b01);
    @(posedge clk); #1;
    b_we = '0;
    @(negedge clk);
    check("b_rd_ready", 32'(b_ready), 32'b01);
    @(posedge clk); #1;
    b_valid = '0;
    @(negedge clk);
    check("b_rsp_valid", 32'(b_rsp_valid), 32'b01);
    check("b_rsp_rdata", 32'(b_rsp_rdata), 32'h3C);
    @(posedge clk); #1;

    repeat (2) @(posedge clk);
    check("sb_drained", sbq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alib_ram_arbiter.md
# alib_ram_arbiter

Round-robin arbiter and sequencer that shares one single-port `alib_bram`/`alib_uram` instance among `NUM_REQ` requesters. After reset it drives the RAM enable, optionally clears every location, and then grants at most one read or write per cycle. Read data comes back to the owning requester with a fixed one-cycle latency. It sits between accelerator-side clients and the RAM primitive, and owns every RAM control pin.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..8.
- `DATA_WIDTH`, 8: RAM word width.
- `DEPTH`, 1024: RAM depth. `AW = $clog2(DEPTH-1)`, identical to the RAM address port.
- `CLEAR_ON_RESET`, 1: when 1, write zero to all `DEPTH` words before accepting requests.

Ports:
- `clk` in 1: single clock for arbiter and RAM.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in `NUM_REQ`: request pending, one bit per requester.
- `req_ready` out `NUM_REQ`: one-hot grant; a transfer occurs when valid and ready are both high.
- `req_we` in `NUM_REQ`: 1 = write, 0 = read.
- `req_addr` in `NUM_REQ*AW`: flattened; requester i uses bits [i*AW +: AW].
- `req_wdata` in `NUM_REQ*DATA_WIDTH`: flattened write data.
- `rsp_valid` out `NUM_REQ`: one-cycle pulse marking read data for requester i.
- `rsp_rdata` out `DATA_WIDTH`: shared read-data bus, meaningful only while a `rsp_valid` bit is set.
- `init_done` out 1: high while in state RUN.
- `ram_en` out 1: drives the RAM `rst` (enable) pin.
- `ram_we` out 1: RAM write enable.
- `ram_addr` out `AW`: RAM address.
- `ram_din` out `DATA_WIDTH`: RAM write data.
- `ram_dout` in `DATA_WIDTH`: RAM read data, registered inside the RAM.

## Operation
- FSM states:
  - WAKE: reset state.
  - CLEAR.
  - RUN.
- FSM transitions:
  - WAKE → CLEAR after one cycle if `CLEAR_ON_RESET`, otherwise WAKE → RUN.
  - CLEAR → RUN on the edge where `clr_cnt == DEPTH-1`.
  - RUN is terminal until reset.
- `ram_en`:
  - Registered; 0 in reset.
  - Set to 1 on the first edge after reset release, then held at 1.
- CLEAR behaviour:
  - `ram_we=1`, `ram_addr=clr_cnt`, `ram_din=0`.
  - `clr_cnt` is AW bits, runs 0..DEPTH-1, and is held at 0 outside CLEAR.
  - `req_ready` is all zero.
- RUN behaviour:
  - Arbitration is combinational over `req_valid`. The search starts at index `ptr+1` modulo `NUM_REQ`; the first valid index wins and its `req_ready` bit is set.
  - `ram_addr`, `ram_din` and `ram_we` are muxed from the winner. `ram_we = req_we[winner]`.
  - With no winner: `ram_we=0`, `ram_addr` holds the last-granted address, `ram_din=0`.
- `ptr`:
  - Registered; reset value `NUM_REQ-1`, so requester 0 wins first.
  - Updated to the winner on every grant; unchanged when idle.
- Granted read: register `rd_pend=1` and `rd_id=winner`. On the next cycle `rsp_valid[rd_id]=1` and `rsp_rdata=ram_dout` (pass-through).
- Writes produce no response. A write is complete at the granting edge.
- `rsp_rdata` is 0 whenever `rd_pend=0`.

## Timing
- Reset values:
  - `req_ready=0`, `rsp_valid=0`, `rsp_rdata=0`, `init_done=0`, `ram_en=0`, `ram_we=0`, `ram_addr=0`, `ram_din=0`.
  - `ptr=NUM_REQ-1`, `rd_pend=0`.
- `init_done` rises `DEPTH+1` edges after reset release when `CLEAR_ON_RESET=1`, and 1 edge after release otherwise.
- Throughput is one access per cycle. Back-to-back grants, including to the same requester, are allowed; read latency stays at 1 cycle regardless.
- Requesters must hold `req_valid`, `req_we`, `req_addr` and `req_wdata` stable until ready. Dropping valid before ready is permitted: the request is treated as withdrawn and no transfer occurs.
- Responses have no backpressure; requesters must accept `rsp_valid` unconditionally.
- Ordering and hazards:
  - A read granted the cycle after a write to the same address returns the new data.
  - Only one access occurs per cycle, so there is no same-cycle hazard.
- Reset asserted mid-operation:
  - All registers clear immediately.
  - A pending read never produces `rsp_valid`.
  - CLEAR restarts from address 0 after reset release.

## Structure
- Shared package `alib_ram_pkg` holds:
  - State encodings `ST_WAKE=2'd0`, `ST_CLEAR=2'd1`, `ST_RUN=2'd2`.
  - The address-width function/localparam `AW` shared with the RAM modules.
- Sub-module `alib_rr_arbiter`:
  - Parameterised by `NUM_REQ`.
  - Inputs: `req`, `ptr`, `en`.
  - Outputs: one-hot `gnt` and binary `gnt_idx`; purely combinational.
- The top level holds the FSM, `clr_cnt`, `ptr`, the `rd_pend`/`rd_id` pipeline register and the RAM muxing.

## Test plan
- `DEPTH=16`, `CLEAR_ON_RESET=1`, RAM preloaded with 0xFF:
  - `init_done` rises at edge 17 after reset release.
  - Reads of addresses 0..15 return 0x00.
- Requester 0 writes 0xA5 to address 5, then reads address 5 on the next cycle:
  - `rsp_valid[0]` pulses one cycle after the read grant.
  - `rsp_rdata=0xA5`.
  - `rsp_valid[1]` stays 0.
- `NUM_REQ=3`, all valid continuously with reads:
  - Grant order is 0,1,2,0,1,2.
  - Each `rsp_valid[i]` is exactly one cycle after its grant.
- Requester 1 alone, valid every cycle for 8 reads of addresses 0..7:
  - 8 grants occur in 8 consecutive cycles.
  - Responses appear in consecutive cycles, in address order.
- Reset asserted the cycle after a read grant:
  - `rsp_valid` stays 0 and all outputs go to reset values asynchronously.
  - After release, CLEAR reruns and `init_done` returns after `DEPTH+1` edges.
- `CLEAR_ON_RESET=0`:
  - `init_done=1` one edge after reset release.
  - Write 0x3C then read it back gives `rsp_rdata=0x3C`.
